// File: rtl/scr1_jtagm_pkg.sv
// Shared types and constants for the SCR1 host-side JTAG master.
package scr1_jtagm_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_IR    = 2'd1,
        OP_DR    = 2'd2,
        OP_RSVD  = 2'd3
    } jtagm_op_e;

    // Each scan state names the TAP state the target occupies during the current TCK cycle.
    typedef enum logic [3:0] {
        ST_TLR_SEQ = 4'd0,
        ST_IDLE    = 4'd1,
        ST_RTI     = 4'd2,
        ST_SEL_DR  = 4'd3,
        ST_SEL_IR  = 4'd4,
        ST_CAPTURE = 4'd5,
        ST_SHIFT   = 4'd6,
        ST_EXIT1   = 4'd7,
        ST_UPDATE  = 4'd8,
        ST_RESP    = 4'd9
    } jtagm_state_e;

    localparam int TLR_LEN = 5;

endpackage

// File: rtl/scr1_jtagm_tck_gen.sv
// TCK divider: low phase then high phase of DIV clk each, one-clk rise/fall strobes.
module scr1_jtagm_tck_gen
    import scr1_jtagm_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt_r;
    logic          tck_r;
    logic          wrap_s;

    assign wrap_s = (cnt_r == CW'(DIV - 1));

    // Phase counter; disabling parks tck low so the next enable starts a fresh low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            tck_r <= 1'b0;
        end else if (!en) begin
            cnt_r <= '0;
            tck_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            tck_r <= ~tck_r;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tck  = tck_r;
    assign rise = en & wrap_s & ~tck_r;
    assign fall = en & wrap_s & tck_r;

endmodule

// File: rtl/scr1_jtag_master.sv
// Host-side JTAG initiator: TMS sequencer, TDI/TDO shifters and command/response handshake.
// Optional trst_n output is enabled by defining SCR1_JTAGM_TRST_EN.
module scr1_jtag_master
    import scr1_jtagm_pkg::*;
#(
    parameter int SCR1_MAX_LEN = 64,
    parameter int SCR1_TCK_DIV = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [$clog2(SCR1_MAX_LEN+1)-1:0] cmd_len,
    input  logic [SCR1_MAX_LEN-1:0]           cmd_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [SCR1_MAX_LEN-1:0]           rsp_data,
    output logic                              rsp_err,
    output logic                              tck,
    output logic                              tms,
    output logic                              tdi,
    input  logic                              tdo
`ifdef SCR1_JTAGM_TRST_EN
    ,
    output logic                              trst_n
`endif
);

    localparam int LW = $clog2(SCR1_MAX_LEN + 1);
    localparam int CW = (LW > 3) ? LW : 3;

    jtagm_state_e            state_r;
    jtagm_op_e               op_r;
    logic [LW-1:0]           len_r;
    logic [SCR1_MAX_LEN-1:0] tx_r;
    logic [SCR1_MAX_LEN-1:0] rx_r;
    logic [CW-1:0]           cnt_r;
    logic                    boot_r;
    logic                    tms_r;
    logic                    tdi_r;
    logic                    cmd_ready_r;
    logic                    rsp_valid_r;
    logic                    rsp_err_r;
    logic [SCR1_MAX_LEN-1:0] rsp_data_r;

    logic          en_s;
    logic          rise_s;
    logic          fall_s;
    logic          accept_s;
    logic          bad_s;
    logic [CW-1:0] len_m1_s;

    scr1_jtagm_tck_gen #(
        .DIV (SCR1_TCK_DIV)
    ) u_tck_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_s),
        .tck   (tck),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign accept_s = cmd_valid & cmd_ready_r;
    assign bad_s    = (cmd_op == OP_RSVD) || (cmd_len > LW'(SCR1_MAX_LEN));
    assign len_m1_s = CW'(len_r) - CW'(1);

    // TCK runs whenever a pin sequence is in progress.
    always_comb begin
        en_s = 1'b1;
        case (state_r)
            ST_IDLE, ST_RESP: en_s = 1'b0;
            default:          en_s = 1'b1;
        endcase
    end

    // TMS sequencer: every TCK fall ends one cycle and presents tms/tdi for the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_TLR_SEQ;
            op_r        <= OP_RESET;
            len_r       <= '0;
            tx_r        <= '0;
            rx_r        <= '0;
            cnt_r       <= '0;
            boot_r      <= 1'b1;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            case (state_r)
                ST_TLR_SEQ: if (fall_s) begin
                    if (cnt_r == CW'(TLR_LEN)) begin
                        cnt_r <= '0;
                        tms_r <= 1'b0;
                        if (boot_r) begin
                            boot_r      <= 1'b0;
                            cmd_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_data_r  <= '0;
                            state_r     <= ST_RESP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        tms_r <= (cnt_r != CW'(TLR_LEN - 1));
                    end
                end
                ST_IDLE: if (accept_s) begin
                    cmd_ready_r <= 1'b0;
                    op_r        <= jtagm_op_e'(cmd_op);
                    len_r       <= cmd_len;
                    tx_r        <= cmd_data;
                    rx_r        <= '0;
                    cnt_r       <= '0;
                    if (bad_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= '0;
                        state_r     <= ST_RESP;
                    end else if (cmd_op == OP_RESET) begin
                        tms_r   <= 1'b1;
                        state_r <= ST_TLR_SEQ;
                    end else begin
                        tms_r   <= 1'b1;
                        state_r <= ST_RTI;
                    end
                end
                ST_RTI: if (fall_s) begin
                    tms_r   <= (op_r == OP_IR);
                    state_r <= ST_SEL_DR;
                end
                ST_SEL_DR: if (fall_s) begin
                    if (op_r == OP_IR) begin
                        tms_r   <= 1'b0;
                        state_r <= ST_SEL_IR;
                    end else begin
                        tms_r   <= (len_r == '0);
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_SEL_IR: if (fall_s) begin
                    tms_r   <= (len_r == '0);
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: if (fall_s) begin
                    if (len_r == '0) begin
                        tms_r   <= 1'b1;
                        state_r <= ST_EXIT1;
                    end else begin
                        cnt_r   <= '0;
                        tms_r   <= (len_m1_s == '0);
                        tdi_r   <= tx_r[0];
                        tx_r    <= tx_r >> 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise_s) begin
                        rx_r <= rx_r | (SCR1_MAX_LEN'(tdo) << cnt_r);
                    end
                    if (fall_s) begin
                        if (cnt_r == len_m1_s) begin
                            tms_r   <= 1'b1;
                            tdi_r   <= 1'b0;
                            state_r <= ST_EXIT1;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                            tms_r <= ((cnt_r + CW'(1)) == len_m1_s);
                            tdi_r <= tx_r[0];
                            tx_r  <= tx_r >> 1'b1;
                        end
                    end
                end
                ST_EXIT1: if (fall_s) begin
                    tms_r   <= 1'b0;
                    state_r <= ST_UPDATE;
                end
                ST_UPDATE: if (fall_s) begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_data_r  <= rx_r;
                    state_r     <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_data_r  <= '0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    cnt_r       <= '0;
                    boot_r      <= 1'b1;
                    tms_r       <= 1'b1;
                    tdi_r       <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    state_r     <= ST_TLR_SEQ;
                end
            endcase
        end
    end

`ifdef SCR1_JTAGM_TRST_EN
    logic trst_r;

    // trst_n low for the whole TLR sequence, both after reset and for a RESET op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trst_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && accept_s && !bad_s && (cmd_op == OP_RESET)) begin
            trst_r <= 1'b0;
        end else if ((state_r == ST_TLR_SEQ) && fall_s && (cnt_r == CW'(TLR_LEN))) begin
            trst_r <= 1'b1;
        end else begin
            trst_r <= trst_r;
        end
    end

    assign trst_n = trst_r;
`endif

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_data  = rsp_data_r;
    assign tms       = tms_r;
    assign tdi       = tdi_r;

endmodule
